// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC execute path: opcodes, one-hot ALU
// ops, decode-stage FSM states and condition-code bit positions.
package risc_pkg;

    localparam logic [4:0] OPC_NOP  = 5'd0;
    localparam logic [4:0] OPC_ADD  = 5'd1;
    localparam logic [4:0] OPC_SUB  = 5'd2;
    localparam logic [4:0] OPC_INC  = 5'd3;
    localparam logic [4:0] OPC_AND  = 5'd4;
    localparam logic [4:0] OPC_DEC  = 5'd5;
    localparam logic [4:0] OPC_OR   = 5'd6;
    localparam logic [4:0] OPC_NOT  = 5'd7;
    localparam logic [4:0] OPC_LDM  = 5'd8;
    localparam logic [4:0] OPC_SETC = 5'd9;
    localparam logic [4:0] OPC_CLRC = 5'd10;

    localparam logic [6:0] ALU_ADD = 7'b000_0001;
    localparam logic [6:0] ALU_SUB = 7'b000_0010;
    localparam logic [6:0] ALU_INC = 7'b000_0100;
    localparam logic [6:0] ALU_AND = 7'b000_1000;
    localparam logic [6:0] ALU_DEC = 7'b001_0000;
    localparam logic [6:0] ALU_OR  = 7'b010_0000;
    localparam logic [6:0] ALU_NOT = 7'b100_0000;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_e;

    localparam int CCR_CF = 2;
    localparam int CCR_NF = 1;
    localparam int CCR_ZF = 0;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode into ALU controls and record-kind flags.
module op_decoder
    import risc_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [4:0]      opcode_i,
    output logic [OP_W-1:0] alu_op_o,
    output logic            alu_en_o,
    output logic            wb_en_o,
    output logic            is_ldm_o,
    output logic            is_setc_o,
    output logic            is_clrc_o,
    output logic            illegal_o
);

    always_comb begin
        alu_op_o  = '0;
        alu_en_o  = 1'b0;
        wb_en_o   = 1'b0;
        is_ldm_o  = 1'b0;
        is_setc_o = 1'b0;
        is_clrc_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_NOP:  ;
            OPC_ADD:  alu_op_o = OP_W'(ALU_ADD);
            OPC_SUB:  alu_op_o = OP_W'(ALU_SUB);
            OPC_INC:  alu_op_o = OP_W'(ALU_INC);
            OPC_AND:  alu_op_o = OP_W'(ALU_AND);
            OPC_DEC:  alu_op_o = OP_W'(ALU_DEC);
            OPC_OR:   alu_op_o = OP_W'(ALU_OR);
            OPC_NOT:  alu_op_o = OP_W'(ALU_NOT);
            OPC_LDM:  is_ldm_o  = 1'b1;
            OPC_SETC: is_setc_o = 1'b1;
            OPC_CLRC: is_clrc_o = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
        alu_en_o = |alu_op_o;
        wb_en_o  = |alu_op_o;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Execute-side decode stage: assembles LDM pairs, registers one issue record
// per instruction behind a valid/ready handshake, and owns the CCR.
module alu_decode_stage
    import risc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_op,
    output logic [2:0]        rdst,
    output logic [2:0]        rsrc1,
    output logic [2:0]        rsrc2,
    output logic [DATA_W-1:0] imm,
    output logic              imm_sel,
    output logic              wb_en,
    output logic              illegal,
    input  logic              alu_cf,
    input  logic              alu_nf,
    input  logic              alu_zf,
    output logic [2:0]        ccr
);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic                alu_en_q, alu_en_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [2:0]          rdst_q, rdst_d, rsrc1_q, rsrc1_d, rsrc2_q, rsrc2_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                imm_sel_q, imm_sel_d, wb_en_q, wb_en_d, illegal_q, illegal_d;
    logic                setc_q, setc_d, clrc_q, clrc_d;
    logic [2:0]          ldm_rdst_q, ldm_rdst_d;
    logic [2:0]          ccr_q, ccr_d;

    logic [OP_W-1:0]     dec_alu_op;
    logic                dec_alu_en, dec_wb_en, dec_ldm, dec_setc, dec_clrc, dec_illegal;
    logic                accept, issue;
    logic                unused_bits;

    assign unused_bits = ^instr[1:0];

    op_decoder #(.OP_W(OP_W)) u_dec (
        .opcode_i  (instr[15:11]),
        .alu_op_o  (dec_alu_op),
        .alu_en_o  (dec_alu_en),
        .wb_en_o   (dec_wb_en),
        .is_ldm_o  (dec_ldm),
        .is_setc_o (dec_setc),
        .is_clrc_o (dec_clrc),
        .illegal_o (dec_illegal)
    );

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_OP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = S_OP;
        else if (accept) begin
            if (state_q == S_IMM) state_d = S_OP;
            else if (dec_ldm)     state_d = S_IMM;
        end
    end

    // Record fields hold when idle; only out_valid is cleared on issue/flush.
    always_comb begin
        out_valid_d = out_valid_q;
        alu_en_d    = alu_en_q;
        alu_op_d    = alu_op_q;
        rdst_d      = rdst_q;
        rsrc1_d     = rsrc1_q;
        rsrc2_d     = rsrc2_q;
        imm_d       = imm_q;
        imm_sel_d   = imm_sel_q;
        wb_en_d     = wb_en_q;
        illegal_d   = illegal_q;
        setc_d      = setc_q;
        clrc_d      = clrc_q;
        ldm_rdst_d  = ldm_rdst_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept && state_q == S_IMM) begin
            out_valid_d = 1'b1;
            alu_en_d    = 1'b0;
            alu_op_d    = '0;
            rdst_d      = ldm_rdst_q;
            rsrc1_d     = '0;
            rsrc2_d     = '0;
            imm_d       = instr;
            imm_sel_d   = 1'b1;
            wb_en_d     = 1'b1;
            illegal_d   = 1'b0;
            setc_d      = 1'b0;
            clrc_d      = 1'b0;
        end else if (accept && dec_ldm) begin
            out_valid_d = 1'b0;
            ldm_rdst_d  = instr[10:8];
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_en_d    = dec_alu_en;
            alu_op_d    = dec_alu_op;
            rdst_d      = instr[10:8];
            rsrc1_d     = instr[7:5];
            rsrc2_d     = instr[4:2];
            imm_d       = '0;
            imm_sel_d   = 1'b0;
            wb_en_d     = dec_wb_en;
            illegal_d   = dec_illegal;
            setc_d      = dec_setc;
            clrc_d      = dec_clrc;
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        ccr_d = ccr_q;
        if (issue && !flush) begin
            if (alu_en_q)    ccr_d = {alu_cf, alu_nf, alu_zf};
            else if (setc_q) ccr_d[CCR_CF] = 1'b1;
            else if (clrc_q) ccr_d[CCR_CF] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= '0;
            rdst_q      <= '0;
            rsrc1_q     <= '0;
            rsrc2_q     <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
            setc_q      <= 1'b0;
            clrc_q      <= 1'b0;
            ldm_rdst_q  <= '0;
            ccr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_en_q    <= alu_en_d;
            alu_op_q    <= alu_op_d;
            rdst_q      <= rdst_d;
            rsrc1_q     <= rsrc1_d;
            rsrc2_q     <= rsrc2_d;
            imm_q       <= imm_d;
            imm_sel_q   <= imm_sel_d;
            wb_en_q     <= wb_en_d;
            illegal_q   <= illegal_d;
            setc_q      <= setc_d;
            clrc_q      <= clrc_d;
            ldm_rdst_q  <= ldm_rdst_d;
            ccr_q       <= ccr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_en    = alu_en_q;
    assign alu_op    = alu_op_q;
    assign rdst      = rdst_q;
    assign rsrc1     = rsrc1_q;
    assign rsrc2     = rsrc2_q;
    assign imm       = imm_q;
    assign imm_sel   = imm_sel_q;
    assign wb_en     = wb_en_q;
    assign illegal   = illegal_q;
    assign ccr       = ccr_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed cases then random traffic
// with flush, back-pressure and a deterministic ALU flag stub.
module tb_alu_decode_stage;
    import risc_pkg::*;

    logic        clk;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] instr;
    logic        in_ready, out_valid, alu_en, imm_sel, wb_en, illegal;
    logic [6:0]  alu_op;
    logic [2:0]  rdst, rsrc1, rsrc2, ccr;
    logic [15:0] imm;
    logic        alu_cf, alu_nf, alu_zf;

    alu_decode_stage #(.DATA_W(16), .OP_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_en(alu_en),
        .alu_op(alu_op), .rdst(rdst), .rsrc1(rsrc1), .rsrc2(rsrc2), .imm(imm),
        .imm_sel(imm_sel), .wb_en(wb_en), .illegal(illegal),
        .alu_cf(alu_cf), .alu_nf(alu_nf), .alu_zf(alu_zf), .ccr(ccr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: flags are a fixed function of the record's register fields.
    assign alu_cf = rsrc1[1];
    assign alu_nf = rsrc2[2];
    assign alu_zf = rdst[0];

    typedef struct packed {
        logic        alu_en;
        logic [6:0]  alu_op;
        logic [2:0]  rdst, rsrc1, rsrc2;
        logic [15:0] imm;
        logic        imm_sel, wb_en, illegal, setc, clrc;
    } rec_t;

    rec_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          m_valid, m_imm_state;
    logic [2:0]  m_ldm_rd, m_ccr;
    rec_t        m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t expect_rec(input logic [15:0] w);
        rec_t r;
        int   opc;
        r     = '0;
        opc   = int'(w[15:11]);
        r.rdst  = w[10:8];
        r.rsrc1 = w[7:5];
        r.rsrc2 = w[4:2];
        if (opc >= 1 && opc <= 7) begin
            r.alu_en = 1'b1;
            r.alu_op = 7'(1 << (opc - 1));
            r.wb_en  = 1'b1;
        end else if (opc == 9)  r.setc = 1'b1;
        else if (opc == 10)     r.clrc = 1'b1;
        else if (opc != 0)      r.illegal = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 0; m_imm_state = 0; m_ldm_rd = '0; m_ccr = '0; m_cur = '0;
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model.
    task automatic cycle(input bit v, input logic [15:0] w, input bit rdy, input bit fl);
        rec_t r;
        bit   acc, iss;
        in_valid = v; instr = w; out_ready = rdy; flush = fl;
        @(posedge clk);
        iss = m_valid && rdy;
        acc = v && !fl && (!m_valid || rdy);
        if (iss && !fl) begin
            if (m_cur.alu_en)    m_ccr = {m_cur.rsrc1[1], m_cur.rsrc2[2], m_cur.rdst[0]};
            else if (m_cur.setc) m_ccr[2] = 1'b1;
            else if (m_cur.clrc) m_ccr[2] = 1'b0;
        end
        if (fl) begin
            if (m_valid && !rdy) void'(q.pop_back());
            m_valid = 0;
            m_imm_state = 0;
        end else begin
            if (iss) m_valid = 0;
            if (acc) begin
                if (m_imm_state) begin
                    r = '0;
                    r.rdst = m_ldm_rd; r.imm = w; r.imm_sel = 1'b1; r.wb_en = 1'b1;
                    q.push_back(r); m_cur = r; m_valid = 1; m_imm_state = 0;
                end else if (w[15:11] == 5'd8) begin
                    m_imm_state = 1;
                    m_ldm_rd = w[10:8];
                end else begin
                    r = expect_rec(w);
                    q.push_back(r); m_cur = r; m_valid = 1;
                end
            end
        end
        #1;
    endtask

    // Monitor: checks handshake/CCR each cycle and pops on every issue.
    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("in_ready", 32'(in_ready), 32'(!flush && (!m_valid || out_ready)));
                chk("ccr", 32'(ccr), 32'(m_ccr));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL issue_unexpected: got record with empty scoreboard at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("rec_alu_en", 32'(alu_en), 32'(e.alu_en));
                        chk("rec_alu_op", 32'(alu_op), 32'(e.alu_op));
                        chk("rec_rdst", 32'(rdst), 32'(e.rdst));
                        chk("rec_imm_sel", 32'(imm_sel), 32'(e.imm_sel));
                        chk("rec_wb_en", 32'(wb_en), 32'(e.wb_en));
                        chk("rec_illegal", 32'(illegal), 32'(e.illegal));
                        if (e.imm_sel) chk("rec_imm", 32'(imm), 32'(e.imm));
                        else           chk("rec_srcs", 32'({rsrc1, rsrc2}), 32'({e.rsrc1, e.rsrc2}));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] w;
        logic [31:0] rnd;
        int          opc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_fields", 32'({alu_en, alu_op}), 0);
        chk("rst_flags", 32'({imm_sel, wb_en, illegal}), 0);
        chk("rst_regs", 32'({rdst, rsrc1, rsrc2}), 0);
        chk("rst_imm_ccr", 32'({imm, ccr}), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // ADD R1,R2,R3 and its CCR update from the stub (CF1 NF0 ZF1)
        cycle(1, 16'h094C, 1, 0);
        chk("add_op", 32'({out_valid, alu_op}), 32'({1'b1, 7'b000_0001}));
        chk("add_regs", 32'({rdst, rsrc1, rsrc2, wb_en}), 32'({3'd1, 3'd2, 3'd3, 1'b1}));
        cycle(0, 16'h0, 1, 0);
        chk("add_ccr", 32'(ccr), 32'(3'b101));

        // LDM R5, 0xBEEF
        cycle(1, 16'h4500, 1, 0);
        chk("ldm_first_no_rec", 32'(out_valid), 0);
        cycle(1, 16'hBEEF, 1, 0);
        chk("ldm_rec", 32'({imm_sel, imm, rdst, alu_en}), 32'({1'b1, 16'hBEEF, 3'd5, 1'b0}));
        cycle(0, 16'h0, 1, 0);
        chk("ldm_ccr", 32'(ccr), 32'(3'b101));

        // DEC R0 held for three cycles of back-pressure
        cycle(1, 16'h2800, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 16'h0, 0, 0);
            chk("dec_hold_op", 32'({out_valid, alu_op}), 32'({1'b1, 7'b001_0000}));
            chk("dec_hold_ready", 32'(in_ready), 0);
            chk("dec_hold_ccr", 32'(ccr), 32'(3'b101));
        end
        cycle(0, 16'h0, 1, 0);
        chk("dec_ccr", 32'(ccr), 32'(3'b000));

        // ADD R1,R0,R4 gives CCR 011, then SETC, CLRC
        cycle(1, 16'h0910, 1, 0);
        cycle(1, 16'h4800, 1, 0);
        chk("pre_setc_ccr", 32'(ccr), 32'(3'b011));
        cycle(1, 16'h5000, 1, 0);
        chk("setc_ccr", 32'(ccr), 32'(3'b111));
        cycle(0, 16'h0, 1, 0);
        chk("clrc_ccr", 32'(ccr), 32'(3'b011));

        // Undefined opcode
        cycle(1, 16'hF800, 1, 0);
        chk("illegal_rec", 32'({illegal, wb_en, alu_en}), 32'(3'b100));
        cycle(0, 16'h0, 1, 0);
        chk("illegal_ccr", 32'(ccr), 32'(3'b011));

        // Flush after LDM first word
        cycle(1, 16'h4500, 1, 0);
        cycle(0, 16'h0, 1, 1);
        cycle(1, 16'h094C, 1, 0);
        chk("flush_ldm_add", 32'({alu_op, imm_sel, rdst}), 32'({7'b000_0001, 1'b0, 3'd1}));
        cycle(0, 16'h0, 1, 0);

        // Async reset mid-LDM
        cycle(1, 16'h4500, 1, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ldm_out", 32'({out_valid, alu_en, alu_op, imm_sel, wb_en, illegal}), 0);
        chk("rst_mid_ldm_regs", 32'({rdst, rsrc1, rsrc2, ccr}), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 16'h094C, 1, 0);
        chk("post_rst_add", 32'({out_valid, alu_op, imm_sel}), 32'({1'b1, 7'b000_0001, 1'b0}));
        cycle(0, 16'h0, 1, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rnd = $urandom();
            opc = int'($urandom_range(0, 12));
            if (opc == 12) opc = int'(rnd[31:27]);
            w = {5'(opc), rnd[10:0]};
            cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        repeat (3) cycle(0, 16'h0, 1, 0);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Execute-side decode stage of the 16-bit RISC processor: the block that drives `alu_16bit`'s operand-select, one-hot `OP` and `En` inputs, and consumes its flag outputs. It accepts 16-bit instruction words over a valid/ready handshake and assembles two-word (immediate) instructions. It emits one registered issue record per instruction to the ALU and register file. It owns the condition-code register (CCR), loaded from the ALU flags at issue.

## Interface
Parameters:
- `DATA_W`, 16, instruction and immediate width.
- `OP_W`, 7, width of the one-hot ALU op bus.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops the pending output and any half-assembled LDM.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  stage can accept a word this cycle.
- `instr`  in  16  instruction word, or the LDM immediate word.
- `out_valid`  out  1  issue record valid.
- `out_ready`  in  1  downstream accepts the record.
- `alu_en`  out  1  drives ALU `En`; 1 only for ALU-class records.
- `alu_op`  out  7  one-hot ALU op (bit0 ADD, bit1 SUB, bit2 INC, bit3 AND, bit4 DEC, bit5 OR, bit6 NOT); all zeros when not ALU-class.
- `rdst`, `rsrc1`, `rsrc2`  out  3 each  register indices.
- `imm`  out  16  LDM immediate.
- `imm_sel`  out  1  record is LDM; write `imm` to `rdst`.
- `wb_en`  out  1  record writes `rdst`.
- `illegal`  out  1  record came from an undefined opcode; it is otherwise a NOP.
- `alu_cf`, `alu_nf`, `alu_zf`  in  1 each  ALU flag outputs (combinational from the issue record).
- `ccr`  out  3  {CF, NF, ZF}.

## Operation
- Instruction format: [15:11] opcode, [10:8] rdst, [7:5] rsrc1, [4:2] rsrc2, [1:0] ignored.
- Opcode decoding:
  - 00000 NOP: record with `wb_en` = 0.
  - 00001–00111 ALU-class: `alu_op` = 1 << (opcode−1), `alu_en` = 1, `wb_en` = 1.
  - 01000 LDM: two-word instruction.
  - 01001 SETC and 01010 CLRC: record with `wb_en` = 0.
  - All other opcodes: NOP record with `illegal` = 1.
- FSM states:
  - S_OP: a word accepted with opcode LDM latches `rdst` and moves to S_IMM; no record is produced. Any other accepted word loads a record.
  - S_IMM: the next accepted word becomes `imm`, loads an LDM record (`imm_sel` = 1, `wb_en` = 1), and returns to S_OP.
- `in_ready` = !flush && (!out_valid || out_ready).
- A record is held stable while out_valid && !out_ready.
- CCR updates only on issue (out_valid && out_ready):
  - ALU-class record: CCR <= {alu_cf, alu_nf, alu_zf}.
  - SETC: CF <= 1. CLRC: CF <= 0. NF and ZF are unchanged in both cases.
  - All other records: CCR is unchanged.
- `flush`:
  - Clears `out_valid` and returns the FSM to S_OP. `flush` wins over a simultaneous `in_valid`; that word is not accepted.
  - CCR is retained, and a record issuing in the flush cycle does not update it.

## Timing
- Reset values: `out_valid` 0, `alu_en` 0, `alu_op` 0, `imm_sel` 0, `wb_en` 0, `illegal` 0, all index fields and `imm` 0, `ccr` 0, FSM in S_OP. `in_ready` is 1 after reset is released.
- Latency, single-word instruction: record valid the cycle after the word is accepted.
- Latency, LDM: record valid the cycle after the immediate word is accepted.
- Throughput: one record per cycle while `out_ready` is held high.
- Back-to-back: accepting a new word in the same cycle the current record issues produces no bubble.
- Reset asserted mid-LDM: the FSM returns to S_OP immediately; the immediate is lost.
- Flag sampling: ALU flags are sampled in the issue cycle, one ALU combinational delay after the record's register outputs settle.

## Structure
- Shared package `risc_pkg` holds:
  - opcode constants (OPC_NOP, OPC_ADD … OPC_NOT, OPC_LDM, OPC_SETC, OPC_CLRC);
  - one-hot ALU op constants, shared with `alu_16bit` and the test bench;
  - the FSM state type (S_OP, S_IMM);
  - the CCR bit positions.
- Sub-module `op_decoder`: combinational; opcode → {alu_op, alu_en, wb_en, is_ldm, is_setc, is_clrc, illegal}.
- The top level holds the FSM, the output register, the handshake logic and the CCR.

## Test plan
- ADD R1,R2,R3 (`instr` 0x094C), `out_ready` = 1:
  - next cycle: `out_valid` 1, `alu_op` 7'b000_0001, `rdst` 1, `rsrc1` 2, `rsrc2` 3, `wb_en` 1;
  - with the ALU stub returning CF 1, ZF 1, NF 0, `ccr` becomes 3'b101 the following cycle.
- LDM R5 (0x4500), then 0xBEEF:
  - no record after the first word;
  - after the second word: `imm_sel` 1, `imm` 0xBEEF, `rdst` 5, `alu_en` 0, `ccr` unchanged.
- DEC R0 (0x2800) issued with `out_ready` = 0 for 3 cycles:
  - record held stable with `alu_op` 7'b001_0000;
  - `in_ready` 0 throughout;
  - issues when `out_ready` rises; `ccr` updates only then.
- SETC (0x4800) then CLRC (0x5000) from `ccr` = 3'b011: `ccr` goes to 3'b111, then 3'b011.
- Opcode 11111 (0xF800) → record with `illegal` 1, `wb_en` 0, `alu_en` 0, and `ccr` unchanged.
- Flush after LDM first word, and reset mid-LDM:
  - `flush` asserted after 0x4500 → next word 0x094C decodes as ADD, not as an immediate;
  - `rst` pulsed after 0x4500 → all outputs return to their reset values with no clock edge needed.
